// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer arbiter.
//   SRC_*   : 2-bit source codes, also the priority rank (higher value wins).
//   state_t : arbiter FSM state encoding.
package buzzer_pkg;

  localparam logic [1:0] SRC_KEY  = 2'd0;
  localparam logic [1:0] SRC_TICK = 2'd1;
  localparam logic [1:0] SRC_OK   = 2'd2;
  localparam logic [1:0] SRC_ERR  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator: half-period counter plus toggle flip-flop.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   restart      : start a fresh tone this edge (counter 0, level 1)
//   run          : keep the tone running; when low the generator parks at 0
//   half_period  : half-period in clk cycles (>= 1)
//   tone         : level the tone flip-flop takes at the coming edge, so the
//                  parent can register the buzzer pin without adding latency
module buzzer_tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        run,
  input  logic [31:0] half_period,
  output logic        tone
);

  logic [31:0] half_cnt;
  logic [31:0] half_cnt_next;
  logic        tone_q;

  always_comb begin
    half_cnt_next = '0;
    tone          = 1'b0;
    if (restart) begin
      half_cnt_next = '0;
      tone          = 1'b1;
    end else if (run) begin
      if (half_cnt == half_period - 32'd1) begin
        half_cnt_next = '0;
        tone          = ~tone_q;
      end else begin
        half_cnt_next = half_cnt + 32'd1;
        tone          = tone_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_cnt <= '0;
      tone_q   <= 1'b0;
    end else begin
      half_cnt <= half_cnt_next;
      tone_q   <= tone;
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Shares one piezo buzzer between key-click, countdown-tick, success and
// fail events with fixed priority (err > ok > tick > key) and preemption.
// Each source plays a timed square-wave pattern; the fail pattern has a
// silent window in the middle.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_key/req_tick/req_ok/req_err : 1-cycle request pulses
//   mute                            : force buzzer low, sequencing continues
//   buzzer                          : registered buzzer pin drive
//   busy                            : a pattern is playing
//   active_src                      : source currently playing (valid when busy)
//   drop_cnt                        : saturating count of lost requests
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter logic [31:0] HALF_KEY  = 32'd50000,
  parameter logic [31:0] HALF_TICK = 32'd100000,
  parameter logic [31:0] HALF_OK   = 32'd25000,
  parameter logic [31:0] HALF_ERR  = 32'd100000,
  parameter logic [31:0] DUR_KEY   = 32'd10000000,
  parameter logic [31:0] DUR_TICK  = 32'd5000000,
  parameter logic [31:0] DUR_OK    = 32'd30000000,
  parameter logic [31:0] DUR_ERR   = 32'd15000000,
  parameter logic [31:0] GAP_LO    = 32'd5000000,
  parameter logic [31:0] GAP_HI    = 32'd10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_key,
  input  logic       req_tick,
  input  logic       req_ok,
  input  logic       req_err,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src,
  output logic [7:0] drop_cnt
);

  function automatic logic [31:0] half_of(input logic [1:0] src);
    case (src)
      SRC_KEY:  return HALF_KEY;
      SRC_TICK: return HALF_TICK;
      SRC_OK:   return HALF_OK;
      default:  return HALF_ERR;
    endcase
  endfunction

  function automatic logic [31:0] dur_of(input logic [1:0] src);
    case (src)
      SRC_KEY:  return DUR_KEY;
      SRC_TICK: return DUR_TICK;
      SRC_OK:   return DUR_OK;
      default:  return DUR_ERR;
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  state_t      state;
  state_t      state_next;
  logic [31:0] dur_cnt;
  logic [31:0] dur_next;
  logic [1:0]  src_next;
  logic [1:0]  winner;
  logic [2:0]  n_req;
  logic [2:0]  drops;
  logic        any_req;
  logic        ending;
  logic        start;
  logic        in_gap;
  logic        tone;

  always_comb begin
    any_req = req_key | req_tick | req_ok | req_err;
    n_req   = {2'b0, req_key} + {2'b0, req_tick} + {2'b0, req_ok} + {2'b0, req_err};

    if (req_err)       winner = SRC_ERR;
    else if (req_ok)   winner = SRC_OK;
    else if (req_tick) winner = SRC_TICK;
    else               winner = SRC_KEY;

    // The last cycle of a pattern is treated as free: a request arriving then
    // starts its own pattern whatever its priority.
    ending = (state == ST_PLAY) && (dur_cnt == dur_of(active_src) - 32'd1);
    start  = any_req && ((state == ST_IDLE) || ending || (winner >= active_src));

    // Every request that does not start a pattern is lost.
    drops    = start ? (n_req - 3'd1) : n_req;
    src_next = start ? winner : active_src;

    if (start)       state_next = ST_PLAY;
    else if (ending) state_next = ST_IDLE;
    else             state_next = state;

    if (start)                       dur_next = '0;
    else if (state_next == ST_PLAY)  dur_next = dur_cnt + 32'd1;
    else                             dur_next = '0;

    in_gap = (src_next == SRC_ERR) && (dur_next > GAP_LO) && (dur_next < GAP_HI);
  end

  buzzer_tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (start),
    .run         (state_next == ST_PLAY),
    .half_period (half_of(src_next)),
    .tone        (tone)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dur_cnt    <= '0;
      active_src <= SRC_KEY;
      busy       <= 1'b0;
      buzzer     <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_next;
      dur_cnt    <= dur_next;
      active_src <= src_next;
      busy       <= (state_next == ST_PLAY);
      buzzer     <= (state_next == ST_PLAY) && tone && !in_gap && !mute;
      drop_cnt   <= sat_add(drop_cnt, drops);
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed self-checking bench for buzzer_arbiter with shortened timings.
module tb_buzzer_arbiter;

  localparam int HK = 2,  HT = 3, HO = 1,  HE = 4;
  localparam int DK = 10, DT = 8, DO = 12, DE = 30;
  localparam int GLO = 10, GHI = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_key, req_tick, req_ok, req_err, mute;
  logic       buzzer, busy;
  logic [1:0] active_src;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_arbiter #(
    .HALF_KEY(HK), .HALF_TICK(HT), .HALF_OK(HO), .HALF_ERR(HE),
    .DUR_KEY(DK), .DUR_TICK(DT), .DUR_OK(DO), .DUR_ERR(DE),
    .GAP_LO(GLO), .GAP_HI(GHI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_key(req_key), .req_tick(req_tick), .req_ok(req_ok), .req_err(req_err),
    .mute(mute), .buzzer(buzzer), .busy(busy),
    .active_src(active_src), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Expected buzzer level d cycles into a pattern of source src (no mute).
  function automatic logic exp_buzz(input int src, input int d);
    int h;
    case (src)
      0: h = HK;
      1: h = HT;
      2: h = HO;
      default: h = HE;
    endcase
    if (src == 3 && d > GLO && d < GHI) return 1'b0;
    return ((d / h) % 2) == 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_key = 0; req_tick = 0; req_ok = 0; req_err = 0; mute = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise the given requests for one edge; returns at the negedge after it.
  task automatic pulse(input logic k, input logic t, input logic o, input logic e);
    req_key = k; req_tick = t; req_ok = o; req_err = e;
    @(negedge clk);
    req_key = 0; req_tick = 0; req_ok = 0; req_err = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_key = 'x; req_tick = 'x; req_ok = 'x; req_err = 'x; mute = 'x;
    repeat (3) @(negedge clk);
    n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer got %b want 0", buzzer); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_checks++; if (active_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d want 0", active_src); end
    req_key = 0; req_tick = 0; req_ok = 0; req_err = 0; mute = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_key();
    do_reset();
    pulse(1, 0, 0, 0);
    for (int d = 0; d < DK; d++) begin
      n_checks++; if (buzzer !== exp_buzz(0, d)) begin n_fail++; $display("FAIL key_buzz d=%0d got %b want %b", d, buzzer, exp_buzz(0, d)); end
      n_checks++; if (busy !== 1'b1 || active_src !== 2'd0) begin n_fail++; $display("FAIL key_busy d=%0d got busy=%b src=%0d want 1/0", d, busy, active_src); end
      @(negedge clk);
    end
    n_checks++; if (busy !== 1'b0 || buzzer !== 1'b0) begin n_fail++; $display("FAIL key_end got busy=%b buzz=%b want 0/0", busy, buzzer); end
  endtask

  task automatic test_err();
    do_reset();
    pulse(0, 0, 0, 1);
    for (int d = 0; d < DE; d++) begin
      n_checks++; if (buzzer !== exp_buzz(3, d)) begin n_fail++; $display("FAIL err_buzz d=%0d got %b want %b", d, buzzer, exp_buzz(3, d)); end
      n_checks++; if (busy !== 1'b1 || active_src !== 2'd3) begin n_fail++; $display("FAIL err_busy d=%0d got busy=%b src=%0d want 1/3", d, busy, active_src); end
      @(negedge clk);
    end
    n_checks++; if (busy !== 1'b0 || buzzer !== 1'b0) begin n_fail++; $display("FAIL err_end got busy=%b buzz=%b want 0/0", busy, buzzer); end
  endtask

  task automatic test_preempt();
    do_reset();
    pulse(1, 0, 0, 0);
    repeat (3) @(negedge clk);
    pulse(0, 0, 1, 0);
    for (int d = 0; d < DO; d++) begin
      n_checks++; if (buzzer !== exp_buzz(2, d)) begin n_fail++; $display("FAIL pre_buzz d=%0d got %b want %b", d, buzzer, exp_buzz(2, d)); end
      n_checks++; if (busy !== 1'b1 || active_src !== 2'd2) begin n_fail++; $display("FAIL pre_src d=%0d got busy=%b src=%0d want 1/2", d, busy, active_src); end
      req_tick = (d == 3);
      @(negedge clk);
    end
    req_tick = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pre_end got busy=%b want 0", busy); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL pre_drop got %0d want 1", drop_cnt); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    pulse(1, 1, 0, 1);
    n_checks++; if (active_src !== 2'd3) begin n_fail++; $display("FAIL same_src got %0d want 3", active_src); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL same_drop got %0d want 2", drop_cnt); end
    n_checks++; if (buzzer !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL same_out got buzz=%b busy=%b want 1/1", buzzer, busy); end
  endtask

  task automatic test_end_precedence();
    do_reset();
    pulse(1, 0, 0, 0);
    for (int d = 0; d < DK; d++) begin
      req_tick = (d == DK - 1);
      @(negedge clk);
    end
    req_tick = 0;
    for (int d = 0; d < DT; d++) begin
      n_checks++; if (buzzer !== exp_buzz(1, d) || busy !== 1'b1 || active_src !== 2'd1) begin
        n_fail++; $display("FAIL endprec d=%0d got buzz=%b busy=%b src=%0d want %b/1/1", d, buzzer, busy, active_src, exp_buzz(1, d));
      end
      @(negedge clk);
    end
    n_checks++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL endprec_end got busy=%b drop=%0d want 0/0", busy, drop_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    req_key = 1; req_tick = 1; req_ok = 1; req_err = 1;
    repeat (90) @(negedge clk);
    req_key = 0; req_tick = 0; req_ok = 0; req_err = 0;
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop got %0d want 255", drop_cnt); end
    n_checks++; if (busy !== 1'b1 || active_src !== 2'd3 || buzzer !== 1'b1) begin n_fail++; $display("FAIL sat_out got busy=%b src=%0d buzz=%b want 1/3/1", busy, active_src, buzzer); end
  endtask

  task automatic test_mute_and_reset();
    logic want;
    do_reset();
    pulse(0, 0, 1, 0);
    for (int d = 0; d < DO; d++) begin
      want = (d >= 3 && d <= 5) ? 1'b0 : exp_buzz(2, d);
      n_checks++; if (buzzer !== want || busy !== 1'b1) begin n_fail++; $display("FAIL mute d=%0d got buzz=%b busy=%b want %b/1", d, buzzer, busy, want); end
      mute = (d >= 2 && d <= 4);
      @(negedge clk);
    end
    mute = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mute_end got busy=%b want 0", busy); end
    pulse(0, 0, 1, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (buzzer !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst got buzz=%b busy=%b want 0/0", buzzer, busy); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_key = 0; req_tick = 0; req_ok = 0; req_err = 0; mute = 0;
    test_reset();
    test_key();
    test_err();
    test_preempt();
    test_same_cycle();
    test_end_precedence();
    test_saturate();
    test_mute_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
